// File: rtl/vram_arbiter.sv
// vram_arbiter: shares an async SRAM between display reads (priority in active video) and FIFO-buffered host writes drained in blanking
module vram_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_W-1:0]             disp_addr,
  input  logic                          h_blank,
  input  logic                          v_blank,
  output logic [DATA_W-1:0]             pix_data,
  output logic                          pix_valid,
  input  logic                          host_wr_valid,
  output logic                          host_wr_ready,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [DATA_W-1:0]             host_data,
  output logic [ADDR_W-1:0]             sram_addr,
  input  logic [DATA_W-1:0]             sram_dq_in,
  output logic [DATA_W-1:0]             sram_dq_out,
  output logic                          sram_dq_oe,
  output logic                          sram_oe_n,
  output logic                          sram_we_n,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    underrun_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  typedef enum logic [2:0] {READ, W_SETUP, W_STROBE, W_HOLD, TURN} state_t;
  state_t state_q;
  logic [ADDR_W+DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_d;
  logic [ADDR_W+DATA_W-1:0] head;
  logic blank, full, push, pop, rd_q;
  assign blank = h_blank | v_blank;
  assign full = fifo_level == LW'(FIFO_DEPTH);
  assign host_wr_ready = ~full;
  assign push = host_wr_valid & ~full;
  assign pop = state_q == W_HOLD;
  assign level_d = fifo_level + LW'(push) - LW'(pop);
  assign head = mem_q[rd_ptr_q];
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {host_addr, host_data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= READ;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_level   <= '0;
      rd_q         <= 1'b0;
      pix_valid    <= 1'b0;
      pix_data     <= '0;
      underrun_cnt <= '0;
      sram_addr    <= '0;
      sram_dq_out  <= '0;
      sram_dq_oe   <= 1'b0;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_q + PW'(push);
      rd_ptr_q   <= rd_ptr_q + PW'(pop);
      fifo_level <= level_d;
      rd_q       <= state_q == READ && !blank;
      pix_valid  <= rd_q;
      if (rd_q) pix_data <= sram_dq_in;
      if (!blank && state_q != READ && underrun_cnt != 8'hff) underrun_cnt <= underrun_cnt + 8'd1;
      case (state_q)
        READ: begin
          sram_addr  <= disp_addr;
          sram_oe_n  <= 1'b0;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          if (blank && fifo_level != '0) state_q <= W_SETUP;
        end
        W_SETUP: begin
          sram_addr   <= head[ADDR_W+DATA_W-1:DATA_W];
          sram_dq_out <= head[DATA_W-1:0];
          sram_dq_oe  <= 1'b1;
          sram_oe_n   <= 1'b1;
          sram_we_n   <= 1'b1;
          state_q     <= W_STROBE;
        end
        W_STROBE: begin
          sram_we_n <= 1'b0;
          state_q   <= W_HOLD;
        end
        W_HOLD: begin
          sram_we_n <= 1'b1;
          state_q   <= blank && level_d != '0 ? W_SETUP : TURN;
        end
        TURN: begin
          sram_dq_oe <= 1'b0;
          sram_oe_n  <= 1'b1;
          state_q    <= READ;
        end
        default: state_q <= READ;
      endcase
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of display reads, blank-time write draining, underrun counting and async reset
module tb_vram_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int D  = 8;
  localparam int LW = $clog2(D) + 1;
  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] disp_addr, host_addr, sram_addr;
  logic h_blank, v_blank, host_wr_valid, host_wr_ready;
  logic [DW-1:0] host_data, pix_data, sram_dq_in, sram_dq_out;
  logic pix_valid, sram_dq_oe, sram_oe_n, sram_we_n;
  logic [LW-1:0] fifo_level;
  logic [7:0] underrun_cnt;
  logic [7:0] sram [0:(1<<AW)-1];
  logic [AW-1:0] wa_q [$];
  logic [DW-1:0] wd_q [$];
  int total = 0;
  int bad = 0;
  int we_lo = 0;
  int base, nq;
  always #5 clk = ~clk;
  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .disp_addr(disp_addr), .h_blank(h_blank), .v_blank(v_blank),
    .pix_data(pix_data), .pix_valid(pix_valid), .host_wr_valid(host_wr_valid),
    .host_wr_ready(host_wr_ready), .host_addr(host_addr), .host_data(host_data),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .fifo_level(fifo_level), .underrun_cnt(underrun_cnt)
  );
  assign sram_dq_in = sram_oe_n ? 8'h00 : sram[sram_addr];
  always @(negedge clk)
    if (rst_n && !sram_we_n) begin
      we_lo++;
      wa_q.push_back(sram_addr);
      wd_q.push_back(sram_dq_out);
      sram[sram_addr] = sram_dq_out;
    end
  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_wr_valid = 1'b1;
    host_addr = a;
    host_data = d;
    tick();
    host_wr_valid = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < (1 << AW); i++) sram[i] = pat(AW'(i));
    rst_n = 1'b0;
    disp_addr = 19'h00010;
    h_blank = 1'b0;
    v_blank = 1'b0;
    host_wr_valid = 1'b0;
    host_addr = '0;
    host_data = '0;
    tick(2);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", host_wr_ready, 1);
    rst_n = 1'b1;
    tick();
    chk("rd_addr0", sram_addr, 19'h00010);
    chk("rd_oe_n", sram_oe_n, 0);
    disp_addr = 19'h00011;
    tick();
    chk("rd_addr1", sram_addr, 19'h00011);
    chk("rd_valid0", pix_valid, 1);
    chk("rd_data0", pix_data, pat(19'h00010));
    tick();
    chk("rd_valid1", pix_valid, 1);
    chk("rd_data1", pix_data, pat(19'h00011));
    chk("rd_under", underrun_cnt, 0);
    disp_addr = 19'h00020;
    push(19'h12345, 8'hA5);
    chk("w1_level", fifo_level, 1);
    tick(3);
    chk("w1_held", fifo_level, 1);
    chk("w1_we_idle", sram_we_n, 1);
    base = we_lo;
    h_blank = 1'b1;
    tick();
    chk("w1_dq_off", sram_dq_oe, 0);
    tick();
    chk("w1_setup_addr", sram_addr, 19'h12345);
    chk("w1_setup_dq", sram_dq_out, 8'hA5);
    chk("w1_setup_oe", sram_dq_oe, 1);
    chk("w1_setup_oe_n", sram_oe_n, 1);
    chk("w1_setup_we_n", sram_we_n, 1);
    tick();
    chk("w1_strobe_we_n", sram_we_n, 0);
    chk("w1_strobe_addr", sram_addr, 19'h12345);
    chk("w1_blank_valid", pix_valid, 0);
    tick();
    chk("w1_hold_we_n", sram_we_n, 1);
    chk("w1_hold_dq_oe", sram_dq_oe, 1);
    chk("w1_pop_level", fifo_level, 0);
    tick();
    chk("w1_turn_dq_oe", sram_dq_oe, 0);
    chk("w1_turn_oe_n", sram_oe_n, 1);
    tick();
    chk("w1_read_oe_n", sram_oe_n, 0);
    chk("w1_we_pulses", we_lo - base, 1);
    chk("w1_log_addr", wa_q[wa_q.size()-1], 19'h12345);
    chk("w1_log_data", wd_q[wd_q.size()-1], 8'hA5);
    tick(4);
    h_blank = 1'b0;
    disp_addr = 19'h12345;
    tick(2);
    chk("w1_rb_valid", pix_valid, 1);
    chk("w1_rb_data", pix_data, 8'hA5);
    chk("w1_under", underrun_cnt, 0);
    for (int i = 0; i < D; i++) push(AW'(19'h00100 + i), DW'(8'h10 + i));
    chk("full_level", fifo_level, 8);
    chk("full_ready", host_wr_ready, 0);
    host_wr_valid = 1'b1;
    host_addr = 19'h00108;
    host_data = 8'h18;
    tick(2);
    chk("full_hold_level", fifo_level, 8);
    chk("full_hold_ready", host_wr_ready, 0);
    host_wr_valid = 1'b0;
    base = we_lo;
    nq = wa_q.size();
    v_blank = 1'b1;
    tick(25);
    chk("burst_level", fifo_level, 0);
    chk("burst_dq_oe", sram_dq_oe, 1);
    tick();
    chk("burst_turn_dq_oe", sram_dq_oe, 0);
    chk("burst_turn_oe_n", sram_oe_n, 1);
    tick();
    chk("burst_read_oe_n", sram_oe_n, 0);
    chk("burst_pulses", we_lo - base, 8);
    for (int i = 0; i < D; i++) begin
      chk("burst_addr", wa_q[nq+i], 19'h00100 + i);
      chk("burst_data", wd_q[nq+i], 8'h10 + i);
    end
    chk("burst_under", underrun_cnt, 0);
    v_blank = 1'b0;
    disp_addr = 19'h00300;
    push(19'h00200, 8'h77);
    h_blank = 1'b1;
    tick(3);
    chk("ovr_strobe", sram_we_n, 0);
    h_blank = 1'b0;
    tick();
    chk("ovr_hold_valid", pix_valid, 0);
    chk("ovr_hold_under", underrun_cnt, 1);
    tick();
    chk("ovr_turn_valid", pix_valid, 0);
    chk("ovr_under", underrun_cnt, 2);
    tick();
    chk("ovr_read_valid", pix_valid, 0);
    chk("ovr_read_addr", sram_addr, 19'h00300);
    chk("ovr_read_oe_n", sram_oe_n, 0);
    tick();
    chk("ovr_resume_valid", pix_valid, 1);
    chk("ovr_resume_data", pix_data, pat(19'h00300));
    chk("ovr_under_hold", underrun_cnt, 2);
    chk("ovr_log_addr", wa_q[wa_q.size()-1], 19'h00200);
    chk("ovr_log_data", wd_q[wd_q.size()-1], 8'h77);
    for (int i = 0; i < 80; i++) begin
      push(AW'(19'h00400 + i), DW'(i));
      h_blank = 1'b1;
      tick();
      h_blank = 1'b0;
      tick(5);
      if (i == 9) chk("sat_mid", underrun_cnt, 42);
    end
    chk("sat_255", underrun_cnt, 255);
    tick(3);
    chk("sat_hold", underrun_cnt, 255);
    push(19'h00500, 8'h11);
    push(19'h00501, 8'h22);
    h_blank = 1'b1;
    tick(3);
    chk("arst_we_low", sram_we_n, 0);
    chk("arst_dq_on", sram_dq_oe, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we_n", sram_we_n, 1);
    chk("arst_dq_oe", sram_dq_oe, 0);
    chk("arst_oe_n", sram_oe_n, 1);
    chk("arst_level", fifo_level, 0);
    chk("arst_ready", host_wr_ready, 1);
    chk("arst_under", underrun_cnt, 0);
    chk("arst_addr", sram_addr, 0);
    h_blank = 1'b0;
    tick();
    rst_n = 1'b1;
    disp_addr = 19'h00040;
    tick();
    chk("arst_read_oe_n", sram_oe_n, 0);
    chk("arst_read_addr", sram_addr, 19'h00040);
    tick();
    chk("arst_read_valid", pix_valid, 1);
    chk("arst_read_data", pix_data, pat(19'h00040));
    chk("arst_level_after", fifo_level, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one external asynchronous SRAM (video memory) between display scan-out reads and host pixel writes.
- Sits between the display timing core and the SRAM pins.
- During active video the display has absolute priority. Host writes queue in an internal FIFO and drain only during blanking, as multi-cycle SRAM write cycles.

Parameters:
ADDR_W, 19, SRAM/display address width
DATA_W, 8, pixel/SRAM data width
FIFO_DEPTH, 8, host write FIFO entries; power of 2, >= 2

Ports:
clk  in  1  system clock (pixel clock domain)
rst_n  in  1  asynchronous active-low reset
disp_addr  in  ADDR_W  scan address from display timing core
h_blank  in  1  horizontal blanking, active high
v_blank  in  1  vertical blanking, active high
pix_data  out  DATA_W  registered pixel read from SRAM
pix_valid  out  1  pix_data holds a correct read for the matching disp_addr
host_wr_valid  in  1  host write request
host_wr_ready  out  1  FIFO can accept; transfer = valid & ready
host_addr  in  ADDR_W  host write address
host_data  in  DATA_W  host write data
sram_addr  out  ADDR_W  SRAM address (registered)
sram_dq_in  in  DATA_W  SRAM data bus input
sram_dq_out  out  DATA_W  SRAM data bus output
sram_dq_oe  out  1  drive sram_dq_out onto bus
sram_oe_n  out  1  SRAM output enable, active low
sram_we_n  out  1  SRAM write enable, active low
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
underrun_cnt  out  8  saturating count of active-video cycles without a display read

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). All outputs are registered except host_wr_ready, which is !full, decoded from the registered level.
- Reset values:
  - state=READ; sram_addr=0; sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
  - pix_data=0, pix_valid=0, fifo_level=0, underrun_cnt=0, host_wr_ready=1.
- Reset mid-write: we_n deasserts immediately; FIFO contents are discarded.
- blank = h_blank | v_blank.
- FIFO:
  - Push on valid & ready. Pop at the end of W_HOLD.
  - Push and pop in the same cycle leaves the level unchanged.
  - At full, ready=0 and no push is accepted, even if a pop happens that cycle.
  - Order is strictly FIFO; pointers wrap modulo FIFO_DEPTH.
- State machine (one transition per clk):
  - READ: sram_addr<=disp_addr, oe_n=0, we_n=1, dq_oe=0. If blank & FIFO non-empty -> W_SETUP.
  - W_SETUP: sram_addr<=head addr, sram_dq_out<=head data, dq_oe=1, oe_n=1, we_n=1 -> W_STROBE.
  - W_STROBE: we_n=0; addr and data held -> W_HOLD.
  - W_HOLD: we_n=1, data still driven, pop head. If blank & FIFO still non-empty (after the pop) -> W_SETUP, else -> TURN.
  - TURN: dq_oe=0, oe_n=1 (bus turnaround) -> READ.
- Once started, a write always completes, even if blank drops mid-sequence.
- Display read latency:
  - disp_addr sampled at edge n appears on sram_addr after edge n.
  - sram_dq_in is sampled into pix_data at edge n+1.
  - pix_valid=1 after edge n+1 iff state was READ and blank=0 at edge n.
  - When pix_valid=0, pix_data holds its previous value.
- Underrun: every edge with blank=0 and state!=READ increments underrun_cnt, saturating at 255. There is no clear other than reset.
- Write throughput: 3 cycles per write, plus 1 TURN cycle per burst. A burst of k writes occupies 3k+1 cycles.
- During blanking with an empty FIFO, the arbiter stays in READ and keeps tracking disp_addr. pix_valid=0 during blank.

Test Plan:
- Reset with active video: rst_n low 2 cycles, blank=0, disp_addr=0x00010 then 0x00011:
  - sram_addr=0x00010 one edge after the first address.
  - pix_data = SRAM model contents; pix_valid=1 two edges after each address; underrun_cnt=0.
- Single write in h_blank: push (0x12345, 0xA5) during active video; assert h_blank for 10 cycles:
  - FIFO holds the write until blank.
  - Sequence SETUP/STROBE/HOLD/TURN; we_n low exactly 1 cycle with sram_addr=0x12345, dq=0xA5.
  - Readback of 0x12345 in active video returns 0xA5.
- Full FIFO: push 9 writes back-to-back with blank=0:
  - ready drops after 8; fifo_level=8; the 9th is held until a pop.
  - In v_blank, all 8 drain in 25 cycles, in push order.
- Write overrun: blank drops during W_STROBE:
  - The write completes.
  - underrun_cnt = 2 (the W_HOLD and TURN edges).
  - pix_valid=0 for the corresponding reads; READ resumes afterwards.
- Saturation: force 300 overrun cycles -> underrun_cnt holds 255.
- Async reset during W_STROBE:
  - we_n=1 and dq_oe=0 immediately, without waiting for a clock edge.
  - fifo_level=0; host_wr_ready=1.
